// File: rtl/simple_processor_pkg.sv
// Shared types and bus widths for the simple processor and its memory-side blocks.
package simple_processor_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one single-port memory between the fetch and data ports,
// with an ack timeout that completes a stuck transaction with an error pulse.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH  = simple_processor_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = simple_processor_pkg::DATA_WIDTH,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  imem_req_i,
  input  logic [ADDR_WIDTH-1:0] imem_addr_i,
  output logic [DATA_WIDTH-1:0] imem_rdata_o,
  output logic                  imem_ack_o,
  input  logic                  dmem_req_i,
  input  logic                  dmem_we_i,
  input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
  input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
  output logic [DATA_WIDTH-1:0] dmem_rdata_o,
  output logic                  dmem_ack_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ack_i,
  output logic                  err_o
);

  import simple_processor_pkg::*;

  localparam int unsigned CntW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(ACK_TIMEOUT - 1);

  arb_state_t state_q, state_d;
  logic                  last_d_q, last_d_d;  // 1: dmem was granted last
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  timeout;
  logic                  done;

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    timeout  = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // dmem takes a tie unless it won the previous grant
        if (dmem_req_i && (!imem_req_i || !last_d_q)) begin
          state_d  = BUSY_D;
          last_d_d = 1'b1;
          cnt_d    = '0;
          we_d     = dmem_we_i;
          addr_d   = dmem_addr_i;
          wdata_d  = dmem_wdata_i;
        end else if (imem_req_i) begin
          state_d  = BUSY_I;
          last_d_d = 1'b0;
          cnt_d    = '0;
          we_d     = 1'b0;
          addr_d   = imem_addr_i;
          wdata_d  = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        timeout = !mem_ack_i && (cnt_q == CntMax);
        done    = mem_ack_i || timeout;
        if (done) begin
          state_d = IDLE;
          cnt_d   = '0;
          we_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign mem_req_o   = (state_q != IDLE);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign err_o       = timeout;

  // A timed-out completion still acks the requester, but with no data
  always_comb begin
    imem_ack_o   = 1'b0;
    dmem_ack_o   = 1'b0;
    imem_rdata_o = '0;
    dmem_rdata_o = '0;
    unique case (state_q)
      BUSY_I: begin
        imem_ack_o   = done;
        imem_rdata_o = timeout ? '0 : mem_rdata_i;
      end
      BUSY_D: begin
        dmem_ack_o   = done;
        dmem_rdata_o = timeout ? '0 : mem_rdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed transactions push expected completions,
// a negedge monitor pops and compares whenever an ack appears.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, dmem_req, dmem_we;
  logic [31:0] imem_addr, dmem_addr, dmem_wdata;
  logic [31:0] imem_rdata, dmem_rdata;
  logic        imem_ack, dmem_ack;
  logic        mem_req, mem_we, mem_ack, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [7:0]  resp_wait;
  logic [7:0]  busy_cyc;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk_i       (clk),
    .arst_ni     (rst_n),
    .imem_req_i  (imem_req),
    .imem_addr_i (imem_addr),
    .imem_rdata_o(imem_rdata),
    .imem_ack_o  (imem_ack),
    .dmem_req_i  (dmem_req),
    .dmem_we_i   (dmem_we),
    .dmem_addr_i (dmem_addr),
    .dmem_wdata_i(dmem_wdata),
    .dmem_rdata_o(dmem_rdata),
    .dmem_ack_o  (dmem_ack),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .mem_ack_i   (mem_ack),
    .err_o       (err)
  );

  function automatic logic [31:0] mem_lookup(input logic [31:0] a);
    case (a)
      32'h0000_1000: mem_lookup = 32'hDEAD_BEEF;
      32'h0000_2000: mem_lookup = 32'hCAFE_F00D;
      32'h0000_2004: mem_lookup = 32'h0BAD_C0DE;
      32'h0000_3000: mem_lookup = 32'h1357_2468;
      default:       mem_lookup = 32'h0;
    endcase
  endfunction

  // Memory responder: acks after resp_wait busy cycles (255 never acks in time)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_cyc <= 8'd0;
    else if (mem_req && !mem_ack) busy_cyc <= busy_cyc + 8'd1;
    else busy_cyc <= 8'd0;
  end
  assign mem_ack   = mem_req && (busy_cyc == resp_wait);
  assign mem_rdata = mem_lookup(mem_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {31'b0, |{mem_req, mem_we, mem_addr, mem_wdata, imem_ack, dmem_ack,
                      imem_rdata, dmem_rdata, err}}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (imem_ack || dmem_ack) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", {30'b0, imem_ack, dmem_ack}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("ack_dmem", {31'b0, dmem_ack}, {31'b0, mon_e.is_d});
        chk("ack_imem", {31'b0, imem_ack}, {31'b0, !mon_e.is_d});
        chk("rdata", mon_e.is_d ? dmem_rdata : imem_rdata, mon_e.rdata);
        chk("other_rdata", mon_e.is_d ? imem_rdata : dmem_rdata, 32'd0);
        chk("err", {31'b0, err}, {31'b0, mon_e.err});
        chk("mem_we", {31'b0, mem_we}, {31'b0, mon_e.we});
        chk("mem_addr", mem_addr, mon_e.addr);
        chk("mem_wdata", mem_wdata, mon_e.wdata);
      end
    end else if (err) begin
      chk("err_without_ack", 32'd1, 32'd0);
    end
  end

  // Called at posedge+1 with the arbiter idle; returns at posedge+1 with the arbiter idle.
  task automatic run_txn(input string nm, input logic is_d, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [7:0] wt,
                         input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                         input logic drop);
    exp_t e;
    int   k;
    bit   seen;
    bit   hold_ok;
    e.is_d  = is_d;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.we    = is_d & we;
    e.addr  = addr;
    e.wdata = is_d ? wdata : 32'd0;
    sb.push_back(e);
    resp_wait = wt;
    if (is_d) begin
      dmem_req = 1'b1; dmem_we = we; dmem_addr = addr; dmem_wdata = wdata;
    end else begin
      imem_req = 1'b1; imem_addr = addr;
    end
    k = 0; seen = 0; hold_ok = 1;
    @(negedge clk);
    chk({nm, "_idle_first"}, {31'b0, mem_req}, 32'd0);
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (imem_ack || dmem_ack) seen = 1;
      if (mem_req && (mem_we !== e.we || mem_addr !== e.addr || mem_wdata !== e.wdata))
        hold_ok = 0;
      if (drop && k == 1) begin
        imem_req = 1'b0; dmem_req = 1'b0;
      end
    end
    chk({nm, "_ack_seen"}, {31'b0, seen}, 32'd1);
    chk({nm, "_latency"}, k, exp_lat);
    chk({nm, "_hold"}, {31'b0, hold_ok}, 32'd1);
    @(posedge clk); #1;
    imem_req = 1'b0; dmem_req = 1'b0; dmem_we = 1'b0; dmem_wdata = 32'd0;
    @(negedge clk);
    chk({nm, "_idle_gap"}, {31'b0, mem_req}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int n;
    exp_t e;
    rst_n = 1'b0;
    imem_req = 1'b0; imem_addr = 32'd0;
    dmem_req = 1'b0; dmem_we = 1'b0; dmem_addr = 32'd0; dmem_wdata = 32'd0;
    resp_wait = 8'd0;
    #2;
    chk_all_zero("reset_outputs");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_txn("fetch_zero_wait", 1'b0, 1'b0, 32'h1000, 32'h0, 8'd0, 32'hDEAD_BEEF, 1'b0, 1, 1'b0);
    run_txn("dmem_write", 1'b1, 1'b1, 32'h2000, 32'h1234_5678, 8'd3, 32'hCAFE_F00D, 1'b0, 4,
            1'b0);
    run_txn("dmem_read", 1'b1, 1'b0, 32'h2004, 32'h0, 8'd2, 32'h0BAD_C0DE, 1'b0, 3, 1'b0);
    run_txn("fetch_wait1", 1'b0, 1'b0, 32'h3000, 32'h0, 8'd1, 32'h1357_2468, 1'b0, 2, 1'b0);
    run_txn("dmem_timeout", 1'b1, 1'b0, 32'h2000, 32'h0, 8'd255, 32'h0, 1'b1, 16, 1'b0);
    run_txn("ack_at_limit", 1'b1, 1'b0, 32'h2000, 32'h0, 8'd15, 32'hCAFE_F00D, 1'b0, 16, 1'b0);
    run_txn("fetch_timeout", 1'b0, 1'b0, 32'h1000, 32'h0, 8'd255, 32'h0, 1'b1, 16, 1'b0);
    run_txn("req_drop_busy", 1'b1, 1'b1, 32'h3000, 32'hA5A5_A5A5, 8'd4, 32'h1357_2468, 1'b0, 5,
            1'b1);

    // Both requesters held from reset release: dmem, imem, dmem, imem with idle gaps
    rst_n = 1'b0;
    imem_req = 1'b1; imem_addr = 32'h1000;
    dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 32'h2004; dmem_wdata = 32'd0;
    resp_wait = 8'd0;
    for (int i = 0; i < 4; i++) begin
      e.is_d  = (i % 2 == 0);
      e.rdata = e.is_d ? 32'h0BAD_C0DE : 32'hDEAD_BEEF;
      e.err   = 1'b0;
      e.we    = 1'b0;
      e.addr  = e.is_d ? 32'h2004 : 32'h1000;
      e.wdata = 32'd0;
      sb.push_back(e);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    k = 0; n = 0;
    while (n < 4 && k < 40) begin
      @(negedge clk);
      if (imem_ack || dmem_ack) begin
        chk($sformatf("rr_slot%0d", n), k, 1 + 2 * n);
        n++;
      end
      k++;
    end
    chk("rr_count", n, 4);
    @(posedge clk); #1;
    imem_req = 1'b0; dmem_req = 1'b0;
    @(negedge clk);
    chk("rr_idle_after", {31'b0, mem_req}, 32'd0);
    @(posedge clk); #1;

    // Reset mid-fetch aborts without an ack
    resp_wait = 8'd6;
    imem_req = 1'b1; imem_addr = 32'h3000;
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy", {31'b0, mem_req}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("abort_outputs");
    imem_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle_after", {31'b0, mem_req}, 32'd0);
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    run_txn("fetch_after_abort", 1'b0, 1'b0, 32'h3000, 32'h0, 8'd0, 32'h1357_2468, 1'b0, 1,
            1'b0);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
